rr_mux4_arbiter: RTL and testbench

RR_MUX4_ARBITER -- requirements
Module: rr_mux4_arbiter

---
 rtl/rr_mux4_arbiter.sv | 146 ++++++++++++++
 tb/tb_rr_mux4_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rr_mux4_arbiter.sv
// Four-channel round-robin arbiter feeding a one-entry registered output stage.
// Define RR_MUX_FIXED_PRIORITY_EN to replace round-robin with fixed priority (x0 highest).
module rr_mux4_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] x3,
    input  logic [3:0]   req,
    output logic [3:0]   grant,
    output logic [W-1:0] y,
    output logic         y_valid,
    input  logic         y_ready,
    output logic [1:0]   sel
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [W-1:0] y_q, y_d;
    logic [1:0]   sel_q, sel_d;
    logic [1:0]   ptr_q, ptr_d;
    logic         load_ok_s;
    logic [3:0]   grant_s;
    logic [1:0]   gidx_s;
    logic [W-1:0] x_sel_s;

    // Search order starts one past the last winner and wraps 3 -> 0.
    function automatic logic [3:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [3:0] g;
        logic [1:0] idx;
        logic       found;
        g     = 4'b0000;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = p + k[1:0];
            if (!found && r[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end else begin
                g = g;
            end
        end
        return g;
    endfunction

    function automatic logic [3:0] fixed_pick(input logic [3:0] r);
        logic [3:0] g;
        g = 4'b0000;
        if (r[0]) begin
            g = 4'b0001;
        end else if (r[1]) begin
            g = 4'b0010;
        end else if (r[2]) begin
            g = 4'b0100;
        end else if (r[3]) begin
            g = 4'b1000;
        end else begin
            g = 4'b0000;
        end
        return g;
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] g);
        logic [1:0] i;
        case (g)
            4'b0010: i = 2'd1;
            4'b0100: i = 2'd2;
            4'b1000: i = 2'd3;
            default: i = 2'd0;
        endcase
        return i;
    endfunction

    assign load_ok_s = (state_q == ST_EMPTY) || y_ready;

    // Grant generation: suppressed during reset or while the output stage is stalled.
    always_comb begin
        grant_s = 4'b0000;
        if (rst || !load_ok_s) begin
            grant_s = 4'b0000;
        end else begin
`ifdef RR_MUX_FIXED_PRIORITY_EN
            grant_s = fixed_pick(req);
`else
            grant_s = rr_pick(req, ptr_q);
`endif
        end
    end

    assign gidx_s = onehot_to_idx(grant_s);

    // Data mux for the granted channel.
    always_comb begin
        case (gidx_s)
            2'd0:    x_sel_s = x0;
            2'd1:    x_sel_s = x1;
            2'd2:    x_sel_s = x2;
            2'd3:    x_sel_s = x3;
            default: x_sel_s = x0;
        endcase
    end

    // Next-state: a grant loads (covers simultaneous consume+load); a bare consume empties.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (grant_s != 4'b0000) begin
            state_d = ST_FULL;
            y_d     = x_sel_s;
            sel_d   = gidx_s;
            ptr_d   = gidx_s;
        end else if ((state_q == ST_FULL) && y_ready) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // State registers; ptr resets to 3 so channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            y_q     <= '0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant   = grant_s;
    assign y       = y_q;
    assign sel     = sel_q;
    assign y_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed self-checking bench for rr_mux4_arbiter; expected values are hand-computed.
module tb_rr_mux4_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] x0, x1, x2, x3;
    logic [3:0] req;
    logic [3:0] grant;
    logic [7:0] y;
    logic       y_valid;
    logic       y_ready;
    logic [1:0] sel;

    int total;
    int bad;

    rr_mux4_arbiter #(.W(8)) dut (
        .clk(clk), .rst(rst),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .req(req), .grant(grant),
        .y(y), .y_valid(y_valid), .y_ready(y_ready), .sel(sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ey, input logic [1:0] es, input logic ev);
        chk({tag, "_y"}, {24'd0, y}, {24'd0, ey});
        chk({tag, "_sel"}, {30'd0, sel}, {30'd0, es});
        chk({tag, "_vld"}, {31'd0, y_valid}, {31'd0, ev});
    endtask

    initial begin
        logic [3:0] exp_g [5];
        logic [7:0] exp_y [5];
        total = 0;
        bad   = 0;
        rst = 1'b1; req = 4'b1111; y_ready = 1'b1;
        x0 = 8'h10; x1 = 8'h11; x2 = 8'h12; x3 = 8'h13;
        #1;
        chk("rst_grant0", {28'd0, grant}, 32'd0);
        tick();
        chk_out("reset", 8'h00, 2'd0, 1'b0);

`ifdef RR_MUX_FIXED_PRIORITY_EN
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("fix_grant", {28'd0, grant}, 32'h1);
            tick();
            chk_out("fix", 8'h10, 2'd0, 1'b1);
        end
`else
        // Single request, one-cycle latency
        rst = 1'b0; req = 4'b0001; x0 = 8'hA5;
        #1;
        chk("single_grant", {28'd0, grant}, 32'h1);
        tick();
        chk_out("single", 8'hA5, 2'd0, 1'b1);

        // Reset mid-FULL, then full round-robin sweep
        rst = 1'b1; req = 4'b1111; x0 = 8'h10;
        #1;
        chk("rst_full_grant0", {28'd0, grant}, 32'd0);
        tick();
        chk_out("rst_full", 8'h00, 2'd0, 1'b0);
        rst = 1'b0;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        exp_y[0] = 8'h10;   exp_y[1] = 8'h11;   exp_y[2] = 8'h12;   exp_y[3] = 8'h13;   exp_y[4] = 8'h10;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_grant", {28'd0, grant}, {28'd0, exp_g[i]});
            tick();
            chk_out("rr", exp_y[i], i[1:0], 1'b1);
        end

        // Load 11, then stall three cycles
        #1;
        chk("pre_stall_grant", {28'd0, grant}, 32'h2);
        tick();
        chk_out("pre_stall", 8'h11, 2'd1, 1'b1);
        y_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_grant", {28'd0, grant}, 32'd0);
            tick();
            chk_out("stall", 8'h11, 2'd1, 1'b1);
        end
        y_ready = 1'b1;
        #1;
        chk("unstall_grant", {28'd0, grant}, 32'h4);
        tick();
        chk_out("unstall", 8'h12, 2'd2, 1'b1);

        // Wrap-around from channel 3 to 0
        #1;
        chk("ch3_grant", {28'd0, grant}, 32'h8);
        tick();
        chk_out("ch3", 8'h13, 2'd3, 1'b1);
        req = 4'b1001;
        #1;
        chk("wrap_grant", {28'd0, grant}, 32'h1);
        tick();
        chk_out("wrap", 8'h10, 2'd0, 1'b1);
        #1;
        chk("wrap3_grant", {28'd0, grant}, 32'h8);
        tick();
        chk_out("wrap3", 8'h13, 2'd3, 1'b1);

        // Consume with no request: go EMPTY, keep y/sel
        req = 4'b0000;
        #1;
        chk("drain_grant", {28'd0, grant}, 32'd0);
        tick();
        chk_out("drain", 8'h13, 2'd3, 1'b0);

        // EMPTY accepts even with y_ready low
        y_ready = 1'b0; req = 4'b0100;
        #1;
        chk("empty_load_grant", {28'd0, grant}, 32'h4);
        tick();
        chk_out("empty_load", 8'h12, 2'd2, 1'b1);

        // Load 55 then reset while FULL
        y_ready = 1'b1; req = 4'b0010; x1 = 8'h55;
        #1;
        chk("load55_grant", {28'd0, grant}, 32'h2);
        tick();
        chk_out("load55", 8'h55, 2'd1, 1'b1);
        rst = 1'b1; req = 4'b1111;
        #1;
        chk("rst55_grant", {28'd0, grant}, 32'd0);
        tick();
        chk_out("rst55", 8'h00, 2'd0, 1'b0);
        rst = 1'b0; req = 4'b1100;
        #1;
        chk("post_rst_grant", {28'd0, grant}, 32'h4);
        tick();
        chk_out("post_rst", 8'h12, 2'd2, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
